// File: rtl/multicycle_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_stage_sequencer_if
//
// Purpose: groups the control/status signals of the multicycle stage
//          sequencer into one bundle.
//
// Modports:
//   master : the core side. Drives run, stage_done, skip_mask, halt_req and
//            observes the stage enables and status.
//   slave  : the sequencer. Consumes the handshakes and drives stage_en,
//            stage_idx, instr_done, busy, halted, retired, timeout_err.
//
// Signals:
//   run         level, 1 = keep sequencing instructions
//   stage_done  per-stage completion handshake
//   skip_mask   stages to skip, sampled at decode-stage completion
//   halt_req    stop bit from decode, sampled at decode-stage completion
//   stage_en    one-hot enable of the active stage
//   stage_idx   index of the active stage
//   instr_done  pulse on the last active cycle of an instruction
//   busy        sequencer is running an instruction stream
//   halted      sequencer has stopped on a halt instruction
//   retired     retired-instruction count
//   timeout_err sticky stage watchdog flag
// ---------------------------------------------------------------------------
interface multicycle_stage_sequencer_if #(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_STAGES);

    logic                  run;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] skip_mask;
    logic                  halt_req;

    logic [NUM_STAGES-1:0] stage_en;
    logic [IDX_W-1:0]      stage_idx;
    logic                  instr_done;
    logic                  busy;
    logic                  halted;
    logic [CNT_W-1:0]      retired;
    logic                  timeout_err;

    modport master (
        output run, stage_done, skip_mask, halt_req,
        input  stage_en, stage_idx, instr_done, busy, halted, retired, timeout_err
    );

    modport slave (
        input  run, stage_done, skip_mask, halt_req,
        output stage_en, stage_idx, instr_done, busy, halted, retired, timeout_err
    );
endinterface

// File: rtl/multicycle_stage_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_stage_sequencer
//
// Purpose: single-clock stage sequencer for the multicycle core. Walks the
//          execution stages one at a time, producing a one-hot stage enable.
//          Stages can be skipped per instruction (mask sampled when the decode
//          stage completes), selected stages wait for a done handshake, and a
//          halt bit from decode stops the sequencer after the instruction
//          finishes. Retired instructions are counted.
//
// Ports:
//   clk    in  system clock, all state on the rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of multicycle_stage_sequencer_if (run, stage_done,
//          skip_mask, halt_req in; stage_en, stage_idx, instr_done, busy,
//          halted, retired, timeout_err out)
//
// Build option:
//   SEQ_TIMEOUT_EN  when defined, a waiting stage is force-completed after
//                   TIMEOUT_CYCLES cycles without its done handshake and the
//                   sticky timeout_err flag is raised. When undefined, waits
//                   are unbounded and timeout_err is tied low.
// ---------------------------------------------------------------------------
module multicycle_stage_sequencer #(
    parameter int unsigned           NUM_STAGES     = 6,
    parameter int unsigned           DECODE_STAGE   = 1,
    parameter logic [NUM_STAGES-1:0] WAIT_MASK      = 6'b010001,
    parameter int unsigned           CNT_W          = 32,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input logic                           clk,
    input logic                           reset,
    multicycle_stage_sequencer_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] EN0 = NUM_STAGES'(1);
    // Only stages after decode can be skipped; lower bits of skip_mask are dropped.
    localparam logic [NUM_STAGES-1:0] SKIP_KEEP = {NUM_STAGES{1'b1}} << (DECODE_STAGE + 1);

    if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("NUM_STAGES must be in 2..16");
    end
    if (DECODE_STAGE == 0 || DECODE_STAGE >= NUM_STAGES) begin : g_bad_decode_stage
        $error("DECODE_STAGE must satisfy 0 < DECODE_STAGE < NUM_STAGES");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

    state_e                state_q,   state_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [NUM_STAGES-1:0] en_q,      en_d;
    logic [NUM_STAGES-1:0] skip_q,    skip_d;
    logic                  halt_q,    halt_d;
    logic                  busy_q,    busy_d;
    logic                  halted_q,  halted_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic                  is_decode;
    logic                  stage_cmp;
    logic                  forced;
    logic [NUM_STAGES-1:0] eff_skip;
    logic                  eff_halt;
    logic                  has_next;
    logic [IDX_W-1:0]      next_idx;
    logic                  instr_end;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              to_err_q, to_err_d;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in a waiting stage.
    assign forced = (state_q == ST_RUN) && WAIT_MASK[idx_q] && !bus.stage_done[idx_q]
                    && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d   = '0;
        to_err_d = to_err_q | forced;
        if (state_q == ST_RUN && !stage_cmp) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q   <= '0;
            to_err_q <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign bus.timeout_err = to_err_q;
`else
    assign forced          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        is_decode = (idx_q == IDX_W'(DECODE_STAGE));
        stage_cmp = (state_q == ST_RUN)
                    && (!WAIT_MASK[idx_q] || bus.stage_done[idx_q] || forced);

        // At decode completion the live inputs decide the route, so that an
        // instruction with everything skipped ends in that same cycle.
        eff_skip = is_decode ? (bus.skip_mask & SKIP_KEEP) : skip_q;
        eff_halt = is_decode ? bus.halt_req : halt_q;

        has_next = 1'b0;
        next_idx = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (!has_next && (i > 32'(idx_q)) && !eff_skip[i]) begin
                has_next = 1'b1;
                next_idx = IDX_W'(i);
            end
        end

        instr_end = stage_cmp && !has_next;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        en_d      = en_q;
        skip_d    = skip_q;
        halt_d    = halt_q;
        busy_d    = busy_q;
        halted_d  = halted_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    en_d    = EN0;
                    busy_d  = 1'b1;
                end
            end

            ST_RUN: begin
                if (stage_cmp) begin
                    if (is_decode) begin
                        skip_d = eff_skip;
                        halt_d = bus.halt_req;
                    end
                    if (has_next) begin
                        idx_d = next_idx;
                        en_d  = EN0 << next_idx;
                    end else begin
                        retired_d = retired_q + CNT_W'(1);
                        skip_d    = '0;
                        halt_d    = 1'b0;
                        idx_d     = '0;
                        if (eff_halt) begin
                            state_d  = ST_HALTED;
                            en_d     = '0;
                            busy_d   = 1'b0;
                            halted_d = 1'b1;
                        end else if (!bus.run) begin
                            state_d = ST_IDLE;
                            en_d    = '0;
                            busy_d  = 1'b0;
                        end else begin
                            en_d = EN0;
                        end
                    end
                end
            end

            ST_HALTED: begin
                en_d = '0;
            end

            default: begin
                state_d  = ST_IDLE;
                idx_d    = '0;
                en_d     = '0;
                busy_d   = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            en_q      <= '0;
            skip_q    <= '0;
            halt_q    <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            en_q      <= en_d;
            skip_q    <= skip_d;
            halt_q    <= halt_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign bus.stage_en   = en_q;
    assign bus.stage_idx  = idx_q;
    assign bus.instr_done = instr_end;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.retired    = retired_q;
endmodule
